// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDiscard
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned FIFO_DEPTH  = 2;
    localparam int unsigned CNT_W       = 2;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO of {pc, instr} pairs; entry 0 is always the head.
module fetch_fifo2
    import pc_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [63:0]      push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic [63:0]      head_o
);

    logic [63:0]      mem_q [FIFO_DEPTH];
    logic [63:0]      mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             do_pop, do_push;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q < CNT_W'(FIFO_DEPTH)) || do_pop);
        wr_idx  = count_q - {1'b0, do_pop};
        if (flush_i) begin
            count_d = '0;
        end else begin
            // Shift toward the head on pop, then write behind the surviving entries.
            if (do_pop) begin
                mem_d[0] = mem_q[1];
            end
            if (do_push) begin
                mem_d[wr_idx[0]] = push_data_i;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one fetch at a time, buffers two words.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      fifo_head;
    logic             fifo_push, fifo_pop, fifo_flush;
    logic             granted;

    // Request only depends on registered state, never on gnt/rvalid/ready.
    assign imem_req    = (state_q == StReq) && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign imem_addr   = pc_q;
    assign granted     = imem_req && imem_gnt;

    assign instr_valid = (fifo_count != '0);
    assign instr_data  = instr_valid ? fifo_head[31:0] : NOP_INSTR;
    assign instr_pc    = instr_valid ? fifo_head[63:32] : 32'h0;
    assign fifo_pop    = instr_valid && instr_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (granted) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'(INSTR_BYTES);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    fifo_push = 1'b1;
                    state_d   = StReq;
                end
            end
            StDiscard: begin
                if (imem_rvalid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides everything; a response still in flight must be swallowed later.
        if (redirect_valid && (state_q != StIdle)) begin
            pc_d       = redirect_pc & ~32'h3;
            fifo_push  = 1'b0;
            fifo_flush = 1'b1;
            if (granted || (((state_q == StWait) || (state_q == StDiscard)) && !imem_rvalid)) begin
                state_d = StDiscard;
            end else begin
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i ({req_pc_q, imem_rdata}),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

endmodule
